// File: rtl/axi_pkg.sv
// Shared AXI3 response/burst codes and responder FSM state encodings.
// Imported by the SRAM responder and by the bridge testbench.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x 32 word memory: combinational read port, byte-enabled write port committing at the clock edge.
// A read of a word being written in the same cycle returns the old contents; no backpressure.
module axi_sram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge aclk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 responder over a word SRAM: first R beat RD_LAT cycles after AR, B response B_LAT cycles after last W.
// One outstanding burst per direction; arready/awready drop while busy, R and B hold until rready/bready.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter logic [31:0] BASE   = 32'h1c00_0000,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned B_LAT  = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  // Widened compare so BASE+4*DEPTH near the top of the address map cannot overflow.
  function automatic logic out_of_range(input logic [31:0] a);
    return ({1'b0, a} < {1'b0, BASE}) || ({1'b0, a} >= LIMIT);
  endfunction

  logic [31:0] ar_off, aw_off;
  assign ar_off = araddr - BASE;
  assign aw_off = awaddr - BASE;

  // Read channel state
  rd_state_t    r_state;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_len, r_cnt;
  logic          r_err;
  logic [7:0]    r_lat;

  // Write channel state
  wr_state_t     w_state;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_len, w_cnt;
  logic          w_err, w_bad;
  logic [7:0]    w_lat;

  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic          w_last_beat;

  // rdata is registered from the address of the beat about to be presented.
  assign mem_raddr   = r_idx + AW'((r_state == R_DATA) ? r_cnt + 2'd1 : r_cnt);
  assign mem_waddr   = w_idx + AW'(w_cnt);
  assign mem_we      = wvalid && wready && !w_err && !areset;
  assign w_last_beat = (w_cnt == w_len);

  axi_sram_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .aclk  (aclk),
    .raddr (mem_raddr),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wstrb (wstrb),
    .wdata (wdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid && arready) begin
          arready <= 1'b0;
          rid     <= arid;
          r_idx   <= ar_off[AW+1:2];
          r_len   <= arlen[1:0];
          r_err   <= out_of_range(araddr);
          r_cnt   <= '0;
          r_lat   <= 8'(RD_LAT - 1);
          r_state <= R_WAIT;
        end
        R_WAIT: if (r_lat == 8'd0) begin
          rvalid  <= 1'b1;
          rlast   <= (r_len == 2'd0);
          rresp   <= resp_of(r_err);
          rdata   <= r_err ? '0 : mem_rdata;
          r_state <= R_DATA;
        end else begin
          r_lat <= r_lat - 8'd1;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
            rlast <= ((r_cnt + 2'd1) == r_len);
            rdata <= r_err ? '0 : mem_rdata;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_bad   <= 1'b0;
      w_lat   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid && awready) begin
          awready <= 1'b0;
          wready  <= 1'b1;
          bid     <= awid;
          w_idx   <= aw_off[AW+1:2];
          w_len   <= awlen[1:0];
          w_err   <= out_of_range(awaddr);
          w_bad   <= 1'b0;
          w_cnt   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid && wready) begin
          w_cnt <= w_cnt + 2'd1;
          // Burst length comes from awlen; wlast only flags a protocol error.
          if (wlast != w_last_beat) w_bad <= 1'b1;
          if (w_last_beat) begin
            wready  <= 1'b0;
            w_lat   <= 8'(B_LAT - 1);
            w_state <= W_RESP;
          end
        end
        W_RESP: if (!bvalid) begin
          if (w_lat == 8'd0) begin
            bvalid <= 1'b1;
            bresp  <= resp_of(w_err || w_bad);
          end else begin
            w_lat <= w_lat - 8'd1;
          end
        end else if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = &{1'b0, arsize, arburst, arlock, arcache, arprot, arlen[7:2],
                    awsize, awburst, awlock, awcache, awprot, awlen[7:2], wid,
                    ar_off[1:0], aw_off[1:0], ar_off[31:AW+2], aw_off[31:AW+2]};

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: directed scenarios plus random write/read bursts against a word-array model.
module tb_axi_sram_responder;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          RD_LAT = 2;
  localparam int          B_LAT  = 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 aclk = ~aclk;

  axi_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT), .B_LAT(B_LAT)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [4];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < {1'b0, BASE} + 33'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a, input int k);
    logic [31:0] t;
    t = ((a - BASE) >> 2) + 32'(k);
    return int'(t % 32'(DEPTH));
  endfunction

  task automatic scramble_ignored();
    arsize = 3'($urandom); arburst = 2'($urandom); arlock = 2'($urandom);
    arcache = 4'($urandom); arprot = 3'($urandom);
    awsize = 3'($urandom); awburst = 2'($urandom); awlock = 2'($urandom);
    awcache = 4'($urandom); awprot = 3'($urandom); wid = 4'($urandom);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [3:0] strb, input int wlast_beat);
    int nb, n, cyc, idx;
    logic [1:0] exp_resp;
    nb = int'(len[1:0]) + 1;
    exp_resp = (!in_rng(addr) || wlast_beat != nb - 1) ? SLVERR : OKAY;
    scramble_ignored();
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    check("awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      wvalid = 1'b1; wdata = wbuf[k]; wstrb = strb; wlast = (k == wlast_beat);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      check("wready", 32'(wready), 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (in_rng(addr)) begin
      for (int k = 0; k < nb; k++) begin
        idx = widx(addr, k);
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][8*b +: 8] = wbuf[k][8*b +: 8];
      end
    end
    check("wready_after_burst", 32'(wready), 32'd0);
    cyc = 0;
    while (!bvalid && cyc < 50) begin tick(); cyc++; end
    check("b_latency", 32'(cyc), 32'(B_LAT));
    check("bresp", 32'(bresp), 32'(exp_resp));
    check("bid", 32'(bid), 32'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("awready_back", 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int stall_beat);
    int nb, n, cyc;
    logic [31:0] exp_d, held_d;
    logic held_l;
    nb = int'(len[1:0]) + 1;
    scramble_ignored();
    rready = 1'b0;
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    check("arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin tick(); cyc++; end
    check("r_latency", 32'(cyc), 32'(RD_LAT));
    for (int k = 0; k < nb; k++) begin
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      exp_d = in_rng(addr) ? model[widx(addr, k)] : 32'h0;
      check("rvalid", 32'(rvalid), 32'd1);
      check("rdata", rdata, exp_d);
      check("rlast", 32'(rlast), 32'(k == nb - 1));
      check("rresp", 32'(rresp), in_rng(addr) ? 32'(OKAY) : 32'(SLVERR));
      check("rid", 32'(rid), 32'(id));
      if (k == stall_beat) begin
        held_d = rdata; held_l = rlast;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_rvalid", 32'(rvalid), 32'd1);
          check("stall_rdata", rdata, held_d);
          check("stall_rlast", 32'(rlast), 32'(held_l));
        end
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("rvalid_after_burst", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, old_word, new_word;
    int cyc;

    areset = 1'b1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0;
    araddr = '0; awaddr = '0; arlen = '0; awlen = '0; arid = '0; awid = '0;
    wdata = '0; wstrb = '0;
    scramble_ignored();
    repeat (3) tick();
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_valids", {29'd0, rvalid, wready, bvalid}, 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_ids", {24'd0, rid, bid}, 32'd0);
    check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    areset = 1'b0;
    tick();

    // Preload words 0..63 and the last two words of the array.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
      do_write(BASE + 32'(16 * i), 8'd3, 4'(i), 4'hF, 3);
    end
    for (int k = 0; k < 2; k++) wbuf[k] = $urandom;
    do_write(BASE + 32'(4 * (DEPTH - 2)), 8'd1, 4'h3, 4'hF, 1);

    do_read(BASE + 32'h10, 8'd0, 4'h9, -1);

    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
    do_write(BASE + 32'h20, 8'd3, 4'hC, 4'hF, 3);
    do_read(BASE + 32'h20, 8'd3, 4'h2, -1);

    wbuf[0] = 32'hFFFF_FFFF;
    do_write(BASE + 32'h40, 8'd0, 4'h1, 4'hF, 0);
    wbuf[0] = 32'h1122_3344;
    do_write(BASE + 32'h40, 8'd0, 4'h1, 4'b0101, 0);
    do_read(BASE + 32'h40, 8'd0, 4'h4, -1);
    check("strobe_merge", rdata === 32'hFF22_FF44 || model[16] === 32'hFF22_FF44 ? 32'd1 : 32'd0, 32'd1);

    do_read(BASE + 32'h80, 8'hF3, 4'h7, 1);

    do_read(BASE + 32'(4 * DEPTH), 8'd0, 4'hA, -1);
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(BASE + 32'(4 * DEPTH), 8'd0, 4'hB, 4'hF, 0);
    do_write(BASE - 32'd4, 8'd0, 4'hD, 4'hF, 0);
    do_read(BASE, 8'd0, 4'h0, -1);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 8'd0, 4'h0, -1);
    wbuf[0] = 32'h5555_0001; wbuf[1] = 32'h5555_0002;
    do_write(BASE + 32'h50, 8'd1, 4'hE, 4'hF, 0);
    do_read(BASE + 32'h50, 8'd1, 4'hE, -1);

    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    do_write(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 4'h8, 4'hF, 3);
    do_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 4'h8, -1);

    // AR and AW to the same word in one cycle; W beat lands on the read-sample edge.
    addr = BASE + 32'h30;
    old_word = model[12];
    new_word = ~old_word;
    araddr = addr; arlen = 8'd0; arid = 4'h5;
    awaddr = addr; awlen = 8'd0; awid = 4'h6;
    check("both_ready", {30'd0, arready, awready}, 32'd3);
    arvalid = 1'b1; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("both_accepted", {29'd0, arready, awready, wready}, 32'd1);
    tick();
    wdata = new_word; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    check("same_cycle_rvalid", 32'(rvalid), 32'd1);
    check("same_cycle_old", rdata, old_word);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 50) begin tick(); cyc++; end
    check("same_cycle_bresp", {29'd0, bvalid, bresp}, 32'h4);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    model[12] = new_word;
    do_read(addr, 8'd0, 4'h5, -1);

    for (int it = 0; it < 24; it++) begin
      logic [7:0] len;
      len = 8'($urandom);
      for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
      do_write(BASE + 4 * $urandom_range(0, 60), len, 4'($urandom), 4'($urandom),
               int'(len[1:0]));
      len = 8'($urandom);
      do_read(BASE + 4 * $urandom_range(0, 60), len, 4'($urandom),
              $urandom_range(0, 4) - 1);
    end

    // Reset while a read burst is being presented.
    araddr = BASE + 32'h40; arlen = 8'd3; arid = 4'h1; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin tick(); cyc++; end
    check("pre_reset_rvalid", 32'(rvalid), 32'd1);
    areset = 1'b1;
    tick();
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_ready", {30'd0, arready, awready}, 32'd3);
    areset = 1'b0;
    tick();
    do_read(BASE + 32'h20, 8'd3, 4'h3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
